addr_gen: RTL
=============

Name: addr_gen

Overview:
- Effective-address sequencer directly upstream of the memory-access stage.
- On each instruction it walks the 6502-style addressing mode: operand bytes from PC, then pointer bytes from zero page or memory.
- It drives address, pc_data and en into the memory-access stage, reads returned bytes, and hands a 16-bit effective address plus a page-cross flag to execute.

Parameters:
- RESET_EA, 16'h0000, value of ea while in reset and for IMP mode.

Ports:
- clk_1  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin sequencing; sampled only in IDLE
- mode  in  4  addressing mode, latched on accepted start
- x  in  8  X index, sampled when used
- y  in  8  Y index, sampled when used
- pc  in  16  current program counter
- rdy  in  1  bus ready; 0 stalls any fetch state
- data_in  in  8  byte read from data bus, valid at end of a fetch cycle
- en  out  1  bus request to the memory-access stage
- pc_data  out  1  1 = drive PC onto bus, 0 = drive address
- address  out  16  pointer/dummy address when pc_data=0
- w_rd  out  1  tied 0 (this block only reads)
- pc_inc  out  1  one-cycle request to increment PC
- busy  out  1  FSM not in IDLE
- ea  out  16  effective address (registered)
- ea_valid  out  1  one-cycle strobe, ea/page_cross valid
- page_cross  out  1  index or branch crossed a 256-byte page (registered)

Behaviour:
- Reset (rst=0, async): state=IDLE; en=0, pc_data=0, address=0, pc_inc=0, busy=0, ea=RESET_EA, ea_valid=0, page_cross=0. Reset mid-sequence aborts; no partial ea is ever strobed.
- Mode encoding: 0 IMP, 1 IMM, 2 ZP, 3 ZPX, 4 ZPY, 5 ABS, 6 ABSX, 7 ABSY, 8 IND, 9 INDX, 10 INDY, 11 REL. Codes 12-15 are treated as IMP.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIX.
- en, pc_data, address and pc_inc are combinational from state and registers. pc_inc = rdy & (OP_LO|OP_HI).
- OP_LO/OP_HI: en=1, pc_data=1. PTR_LO/PTR_HI/FIX: en=1, pc_data=0, address=pointer.
- Stall: rdy=0 freezes state, registers and outputs; data_in is not captured. Each state advances only when rdy=1.
- Completion: the last state returns to IDLE and registers ea, page_cross and ea_valid=1 for exactly one cycle. A start in that same cycle is accepted, giving back-to-back instructions.
- IMP: start -> IDLE next cycle; ea_valid=1, ea=RESET_EA. 1 cycle.
- IMM: start -> one cycle with pc_inc=1, en=0. ea=pc sampled that cycle.
- ZP: OP_LO; ea={8'h00,d}.
- ZPX/ZPY: OP_LO; ea={8'h00,(d+idx)[7:0]}. Wraps within page 0; page_cross=0.
- ABS: OP_LO, OP_HI; ea={hi,lo}.
- ABSX/ABSY: as ABS; ea={hi,lo}+idx (16-bit); page_cross = carry out of the low byte.
- IND: OP_LO, OP_HI, PTR_LO at {hi,lo}, PTR_HI at {hi,lo+1 mod 256}. The high byte does not carry (6502 page-wrap quirk). ea={ptr_hi,ptr_lo}.
- INDX: OP_LO; zp=(d+x)[7:0]. PTR_LO at {00,zp}, PTR_HI at {00,zp+1 mod 256}; page_cross=0.
- INDY: OP_LO, PTR_LO at {00,d}, PTR_HI at {00,d+1 mod 256}. ea=ptr+y; page_cross = low-byte carry.
- REL: OP_LO; base=pc_at_OP_LO+1; ea=base+sext(d). page_cross=(ea[15:8]!=base[15:8]).
- 16-bit address arithmetic wraps modulo 2^16 (e.g. 16'hFFFF+1=16'h0000).

Optional Feature:
- Macro AG_PAGE_FIX_EN.
- Defined: ABSX/ABSY/INDY/REL with page_cross=1 insert a FIX cycle. FIX is a dummy read at {uncorrected_hi, corrected_lo}, matching 6502 timing. ea_valid is delayed one cycle.
- Undefined: no FIX state; page_cross is still reported and downstream owns the penalty.

Decomposition:
- Shared package/include mosby_pkg: mode codes (AM_IMP..AM_REL), FSM state encodings, width constants.
- One sub-module, ea_adder: 16-bit base plus 8-bit index or signed offset. Outputs the sum and the page_cross flag; used by the indexed and REL paths.

Test Plan:
- ABS, bytes 34,12 -> pc_inc on 2 cycles; ea=16'h1234, page_cross=0, ea_valid 2 cycles after start.
- ABSX, bytes FF,12, x=01 -> ea=16'h1300, page_cross=1. With AG_PAGE_FIX_EN: FIX address=16'h1200, ea_valid at cycle 3; without: ea_valid at cycle 2.
- IND, operand 16'h10FF, mem[10FF]=CD, mem[1000]=AB -> PTR_HI address=16'h1000, ea=16'hABCD.
- INDX, d=FE, x=01 -> PTR_LO addr 16'h00FF, PTR_HI addr 16'h0000. ZPX d=F0, x=20 -> ea=16'h0010.
- REL, pc=16'h10FD, d=8'h05 -> ea=16'h1103, page_cross=1. d=8'hF0 at pc=16'h2000 -> ea=16'h1FF1.
- rdy=0 for 3 cycles in OP_HI -> state, address and en held, pc_inc=0. rst low in PTR_LO -> immediate IDLE, no ea_valid; start in the ea_valid cycle -> accepted.

Source files
------------

// File: rtl/mosby_pkg.sv
// Shared definitions for the effective-address sequencer: widths, addressing-mode
// codes and FSM state encodings.
package mosby_pkg;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MW = 4;

  typedef enum logic [MW-1:0] {
    AM_IMP  = 4'd0,
    AM_IMM  = 4'd1,
    AM_ZP   = 4'd2,
    AM_ZPX  = 4'd3,
    AM_ZPY  = 4'd4,
    AM_ABS  = 4'd5,
    AM_ABSX = 4'd6,
    AM_ABSY = 4'd7,
    AM_IND  = 4'd8,
    AM_INDX = 4'd9,
    AM_INDY = 4'd10,
    AM_REL  = 4'd11
  } am_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP_LO  = 3'd1,
    ST_OP_HI  = 3'd2,
    ST_PTR_LO = 3'd3,
    ST_PTR_HI = 3'd4,
    ST_FIX    = 3'd5
  } st_t;

  // Unused encodings 12..15 behave as implied addressing.
  function automatic am_t decode_mode(input logic [MW-1:0] m);
    if (m > 4'd11) begin
      return AM_IMP;
    end
    return am_t'(m);
  endfunction

endpackage

// File: rtl/ea_adder.sv
// Base plus 8-bit index (zero-extended) or branch offset (sign-extended), with the
// page-cross flag and the 6502-style dummy-read address {uncorrected_hi, corrected_lo}.
module ea_adder
  import mosby_pkg::*;
(
  input  logic [AW-1:0] i_base,
  input  logic [DW-1:0] i_idx,
  input  logic          i_signed,
  output logic [AW-1:0] o_sum,
  output logic          o_page_cross,
  output logic [AW-1:0] o_fix_addr
);

  logic [AW-1:0] w_ext;

  assign w_ext        = i_signed ? {{8{i_idx[7]}}, i_idx} : {8'h00, i_idx};
  assign o_sum        = i_base + w_ext;
  // For an unsigned index this equals the carry out of the low byte.
  assign o_page_cross = (o_sum[15:8] != i_base[15:8]);
  assign o_fix_addr   = {i_base[15:8], o_sum[7:0]};

endmodule

// File: rtl/addr_gen.sv
// Effective-address sequencer: walks the 6502 addressing mode over the memory-access
// stage and strobes ea/page_cross to execute. Define AG_PAGE_FIX_EN to add the FIX cycle.
module addr_gen
  import mosby_pkg::*;
#(
  parameter logic [15:0] RESET_EA = 16'h0000
) (
  input  logic          clk_1,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] mode,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [AW-1:0] pc,
  input  logic          rdy,
  input  logic [DW-1:0] data_in,
  output logic          en,
  output logic          pc_data,
  output logic [AW-1:0] address,
  output logic          w_rd,
  output logic          pc_inc,
  output logic          busy,
  output logic [AW-1:0] ea,
  output logic          ea_valid,
  output logic          page_cross
);

`ifdef AG_PAGE_FIX_EN
  localparam logic FIX_EN = 1'b1;
`else
  localparam logic FIX_EN = 1'b0;
`endif

  st_t           r_state;
  am_t           r_mode;
  logic [DW-1:0] r_lo;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_fix_ea;
  logic [AW-1:0] r_ea;
  logic          r_ea_valid;
  logic          r_page_cross;

  logic [AW-1:0] w_add_base;
  logic [DW-1:0] w_add_idx;
  logic          w_add_signed;
  logic [AW-1:0] w_sum;
  logic          w_cross;
  logic [AW-1:0] w_fix_addr;
  logic          w_go_fix;

  // Adder operands depend only on the mode; each mode uses the adder in one state.
  always_comb begin
    w_add_base   = {data_in, r_lo};
    w_add_idx    = x;
    w_add_signed = 1'b0;
    case (r_mode)
      AM_ABSY, AM_INDY: w_add_idx = y;
      AM_REL: begin
        w_add_base   = pc + 16'd1;
        w_add_idx    = data_in;
        w_add_signed = 1'b1;
      end
      default: ;
    endcase
  end

  ea_adder u_ea_adder (
    .i_base      (w_add_base),
    .i_idx       (w_add_idx),
    .i_signed    (w_add_signed),
    .o_sum       (w_sum),
    .o_page_cross(w_cross),
    .o_fix_addr  (w_fix_addr)
  );

  assign w_go_fix = FIX_EN & w_cross;

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= AM_IMP;
      r_lo         <= '0;
      r_ptr        <= '0;
      r_fix_ea     <= '0;
      r_ea         <= RESET_EA;
      r_ea_valid   <= 1'b0;
      r_page_cross <= 1'b0;
    end else begin
      r_ea_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= decode_mode(mode);
            if (decode_mode(mode) == AM_IMP) begin
              r_ea         <= RESET_EA;
              r_page_cross <= 1'b0;
              r_ea_valid   <= 1'b1;
            end else begin
              r_state <= ST_OP_LO;
            end
          end
        end

        ST_OP_LO: begin
          if (rdy) begin
            case (r_mode)
              AM_IMM: begin
                r_ea         <= pc;
                r_page_cross <= 1'b0;
                r_ea_valid   <= 1'b1;
                r_state      <= ST_IDLE;
              end
              AM_ZP: begin
                r_ea         <= {8'h00, data_in};
                r_page_cross <= 1'b0;
                r_ea_valid   <= 1'b1;
                r_state      <= ST_IDLE;
              end
              AM_ZPX: begin
                r_ea         <= {8'h00, data_in + x};
                r_page_cross <= 1'b0;
                r_ea_valid   <= 1'b1;
                r_state      <= ST_IDLE;
              end
              AM_ZPY: begin
                r_ea         <= {8'h00, data_in + y};
                r_page_cross <= 1'b0;
                r_ea_valid   <= 1'b1;
                r_state      <= ST_IDLE;
              end
              AM_ABS, AM_ABSX, AM_ABSY, AM_IND: begin
                r_lo    <= data_in;
                r_state <= ST_OP_HI;
              end
              AM_INDX: begin
                r_ptr   <= {8'h00, data_in + x};
                r_state <= ST_PTR_LO;
              end
              AM_INDY: begin
                r_ptr   <= {8'h00, data_in};
                r_state <= ST_PTR_LO;
              end
              AM_REL: begin
                if (w_go_fix) begin
                  r_ptr    <= w_fix_addr;
                  r_fix_ea <= w_sum;
                  r_state  <= ST_FIX;
                end else begin
                  r_ea         <= w_sum;
                  r_page_cross <= w_cross;
                  r_ea_valid   <= 1'b1;
                  r_state      <= ST_IDLE;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end

        ST_OP_HI: begin
          if (rdy) begin
            case (r_mode)
              AM_ABS: begin
                r_ea         <= {data_in, r_lo};
                r_page_cross <= 1'b0;
                r_ea_valid   <= 1'b1;
                r_state      <= ST_IDLE;
              end
              AM_ABSX, AM_ABSY: begin
                if (w_go_fix) begin
                  r_ptr    <= w_fix_addr;
                  r_fix_ea <= w_sum;
                  r_state  <= ST_FIX;
                end else begin
                  r_ea         <= w_sum;
                  r_page_cross <= w_cross;
                  r_ea_valid   <= 1'b1;
                  r_state      <= ST_IDLE;
                end
              end
              AM_IND: begin
                r_ptr   <= {data_in, r_lo};
                r_state <= ST_PTR_LO;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end

        // Pointer high byte is fetched from the same page: the low byte wraps, no carry.
        ST_PTR_LO: begin
          if (rdy) begin
            r_lo       <= data_in;
            r_ptr[7:0] <= r_ptr[7:0] + 8'd1;
            r_state    <= ST_PTR_HI;
          end
        end

        ST_PTR_HI: begin
          if (rdy) begin
            if (r_mode == AM_INDY) begin
              if (w_go_fix) begin
                r_ptr    <= w_fix_addr;
                r_fix_ea <= w_sum;
                r_state  <= ST_FIX;
              end else begin
                r_ea         <= w_sum;
                r_page_cross <= w_cross;
                r_ea_valid   <= 1'b1;
                r_state      <= ST_IDLE;
              end
            end else begin
              r_ea         <= {data_in, r_lo};
              r_page_cross <= 1'b0;
              r_ea_valid   <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end
        end

        ST_FIX: begin
          if (rdy) begin
            r_ea         <= r_fix_ea;
            r_page_cross <= 1'b1;
            r_ea_valid   <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus controls are decoded from the current state; IMM only bumps the PC.
  always_comb begin
    en      = 1'b0;
    pc_data = 1'b0;
    address = '0;
    pc_inc  = 1'b0;
    case (r_state)
      ST_OP_LO, ST_OP_HI: begin
        en      = (r_mode != AM_IMM);
        pc_data = (r_mode != AM_IMM);
        pc_inc  = rdy;
      end
      ST_PTR_LO, ST_PTR_HI, ST_FIX: begin
        en      = 1'b1;
        address = r_ptr;
      end
      default: ;
    endcase
  end

  assign w_rd       = 1'b0;
  assign busy       = (r_state != ST_IDLE);
  assign ea         = r_ea;
  assign ea_valid   = r_ea_valid;
  assign page_cross = r_page_cross;

endmodule
